// File: rtl/reg_file_pkg.sv
// Shared register-file constants (width, address width, zero-register index)
// used by the register file, decoder and control unit.
package reg_file_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_register_we.sv
// WIDTH-bit rising-edge register with synchronous active-high reset and write
// enable, built from per-bit reset flops fed by a per-bit hold/load mux.
module register_we
    import reg_file_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] bits_q;
    logic [WIDTH-1:0] bits_d;

    for (genvar b = 0; b < WIDTH; b++) begin : g_dffr
        assign bits_d[b] = we_i ? d_i[b] : bits_q[b];

        always_ff @(posedge clk) begin
            if (rst) begin
                bits_q[b] <= 1'b0;
            end else begin
                bits_q[b] <= bits_d[b];
            end
        end
    end

    assign q_o = bits_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 2^ADDR_W x WIDTH, entry 0 reads zero, two async
// read ports, one sync write port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [WIDTH-1:0]    entry_q [NUM_REGS];
    logic [NUM_REGS-1:1] we_dec;

    // wr_en gates every decode term, so X on wr_addr with wr_en low cannot enable a write.
    always_comb begin
        we_dec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            we_dec[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    assign entry_q[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        register_we #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .we_i (we_dec[i]),
            .d_i  (wr_data),
            .q_o  (entry_q[i])
        );
    end

    always_comb begin
        rd_data_a = entry_q[rd_addr_a];
        rd_data_b = entry_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write; address 0 is excluded so r0 stays zero.
        if (wr_en && !rst && (wr_addr != '0) && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && !rst && (wr_addr != '0) && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`else
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected read values are queued when stimulus is
// applied and popped when the read ports are sampled.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] exp_q[$];
    int checks;
    int failures;

    reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Apply read addresses, queue both expectations, then sample after settling.
    task automatic read2(input string tag, input logic [4:0] aa, input logic [31:0] ea,
                         input logic [4:0] ab, input logic [31:0] eb);
        rd_addr_a = aa;
        rd_addr_b = ab;
        push(ea);
        push(eb);
        #1;
        check({tag, "_a"}, rd_data_a);
        check({tag, "_b"}, rd_data_b);
    endtask

    initial begin
        logic [31:0] rdw_before;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        edge_step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read2("reset_sweep", 5'(i), 32'h0, 5'(31 - i), 32'h0);
        end

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        edge_step();
        wr_en = 1'b0;
        read2("write_r5", 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);
        read2("neighbours", 5'd4, 32'h0, 5'd6, 32'h0);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        read2("r0_during_write", 5'd0, 32'h0, 5'd0, 32'h0);
        edge_step();
        wr_en = 1'b0;
        read2("r0_after_write", 5'd0, 32'h0, 5'd5, 32'hDEADBEEF);
        edge_step();
        read2("r0_later", 5'd0, 32'h0, 5'd0, 32'h0);

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000001;
        edge_step();
        wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'hFFFFFFFF;
        edge_step();
        read2("we_gate", 5'd7, 32'h00000001, 5'd5, 32'hDEADBEEF);
        wr_addr = 'x; wr_data = 'x;
        edge_step();
        read2("x_safe", 5'd7, 32'h00000001, 5'd5, 32'hDEADBEEF);
        read2("x_safe_r1", 5'd1, 32'h0, 5'd31, 32'h0);

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        rst = 1'b1;
        read2("pre_reset", 5'd5, 32'hDEADBEEF, 5'd7, 32'h00000001);
        edge_step();
        rst = 1'b0; wr_en = 1'b0;
        read2("rst_collision", 5'd9, 32'h0, 5'd9, 32'h0);
        read2("rst_cleared", 5'd5, 32'h0, 5'd7, 32'h0);

        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000011;
        edge_step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000022;
`ifdef REGFILE_BYPASS_EN
        rdw_before = 32'h00000022;
`else
        rdw_before = 32'h00000011;
`endif
        read2("rdw_before", 5'd3, rdw_before, 5'd3, rdw_before);
        read2("rdw_other_port", 5'd3, rdw_before, 5'd4, 32'h0);
        edge_step();
        wr_en = 1'b0;
        read2("rdw_after", 5'd3, 32'h00000022, 5'd3, 32'h00000022);

        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h80000001;
        edge_step();
        wr_en = 1'b0;
        read2("top_entry", 5'd31, 32'h80000001, 5'd30, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
